// File: rtl/clock_pkg.sv
// clock_pkg: shared types, constants and BCD helpers for the clock chain.
//   bcd_digit_t   - one BCD digit (4 bits)
//   bcd2_t        - two BCD digits, tens in [7:4]
//   bcd_inc_t     - result of a mod-60 BCD increment: wrap flag + next value
//   bcd_inc_mod60 - 00..59 increment; also used by the hour stage's set logic
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd2_t;

    typedef struct packed {
        logic  wrap;
        bcd2_t value;
    } bcd_inc_t;

    localparam bcd2_t BCD_59   = 8'h59;
    localparam bcd2_t BCD_ZERO = 8'h00;

    // Illegal codes (digit > 9 or tens > 5) recover to 00 without flagging a wrap,
    // so an upset value can never produce a carry into the next stage.
    function automatic bcd_inc_t bcd_inc_mod60(input bcd2_t v);
        bcd_inc_t   r;
        bcd_digit_t tens;
        bcd_digit_t ones;
        tens    = v[7:4];
        ones    = v[3:0];
        r.wrap  = 1'b0;
        r.value = BCD_ZERO;
        if (tens > 4'd5 || ones > 4'd9) begin
            r.value = BCD_ZERO;
        end else if (v == BCD_59) begin
            r.wrap = 1'b1;
        end else if (ones == 4'd9) begin
            r.value = {tens + 4'd1, 4'd0};
        end else begin
            r.value = {tens, ones + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, optional stable-count filter and press pulse.
//   clk   - system clock, rising edge
//   clr   - asynchronous active-high reset; all state released to 0
//   btn   - raw asynchronous button, active-high
//   press - one-cycle pulse on each accepted 0->1 transition
// Macro MS_DEBOUNCE_EN: when defined, the accepted level changes only after
// DEB_CYCLES consecutive equal synchronised samples; otherwise the synchronised
// input is the accepted level and DEB_CYCLES has no effect.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic press
);

    if (DEB_CYCLES < 2) begin : g_deb_chk
        $error("btn_debounce: DEB_CYCLES must be at least 2");
    end

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic level_prev_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

`ifdef MS_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          level_q;

    // cnt_q counts consecutive samples that disagree with the accepted level;
    // the DEB_CYCLES-th such sample flips the level.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync2_q == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            level_prev_q <= 1'b0;
        end else begin
            level_prev_q <= level;
        end
    end

    assign press = level & ~level_prev_q;

endmodule

// File: rtl/min_sec_counter.sv
// min_sec_counter: BCD seconds/minutes stage of the clock chain.
//   clk      - system clock, rising edge
//   clr      - asynchronous active-high reset
//   set_mode - 1 = set mode, 0 = run mode (asynchronous, synchronised here)
//   btn_min  - raw minute-advance button (acts in set mode only)
//   btn_hour - raw hour-advance button (acts in set mode only)
//   sec, min - two-digit BCD seconds and minutes, tens in [7:4]
//   hour_inc - one-cycle pulse advancing the hour stage
//   sec_tick - one-cycle pulse on every one-second prescaler wrap
// PRESC_DIV clock cycles form one second. Macro MS_DEBOUNCE_EN (in btn_debounce)
// enables the DEB_CYCLES button filter.
module min_sec_counter
    import clock_pkg::*;
#(
    parameter int unsigned PRESC_DIV  = 1000,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       set_mode,
    input  logic       btn_min,
    input  logic       btn_hour,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic       hour_inc,
    output logic       sec_tick
);

    if (PRESC_DIV < 2) begin : g_presc_chk
        $error("min_sec_counter: PRESC_DIV must be at least 2");
    end

    localparam int unsigned PW = $clog2(PRESC_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);

    logic          set1_q;
    logic          set_sync_q;
    logic [PW-1:0] presc_q, presc_d;
    bcd2_t         sec_q, sec_d;
    bcd2_t         min_q, min_d;
    logic          hour_inc_q, hour_inc_d;
    logic          min_press;
    logic          hour_press;
    bcd_inc_t      sec_nxt;
    bcd_inc_t      min_nxt;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_min (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn_min),
        .press (min_press)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_hour (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn_hour),
        .press (hour_press)
    );

    // Set mode gates the tick, so a wrap coinciding with entry into set mode is dropped.
    assign sec_tick = ~set_sync_q & (presc_q == PRESC_MAX);

    always_comb begin
        presc_d    = presc_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_inc_d = 1'b0;
        sec_nxt    = bcd_inc_mod60(sec_q);
        min_nxt    = bcd_inc_mod60(min_q);
        if (set_sync_q) begin
            // Holding the prescaler at 0 makes the first second after exit a full one.
            presc_d = '0;
            sec_d   = BCD_ZERO;
            if (min_press) begin
                min_d = min_nxt.value;
            end
            // Keeps pulses separated when a run-mode carry is directly followed by a press.
            hour_inc_d = hour_press & ~hour_inc_q;
        end else if (sec_tick) begin
            presc_d = '0;
            sec_d   = sec_nxt.value;
            if (sec_nxt.wrap) begin
                min_d      = min_nxt.value;
                hour_inc_d = min_nxt.wrap;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            set1_q     <= 1'b0;
            set_sync_q <= 1'b0;
            presc_q    <= '0;
            sec_q      <= BCD_ZERO;
            min_q      <= BCD_ZERO;
            hour_inc_q <= 1'b0;
        end else begin
            set1_q     <= set_mode;
            set_sync_q <= set1_q;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_inc_q <= hour_inc_d;
        end
    end

    assign sec      = sec_q;
    assign min      = min_q;
    assign hour_inc = hour_inc_q;

endmodule
